// File: rtl/plic_pkg.sv
// plic_pkg: shared definitions for the PLIC target slice.
//
// Holds the default sizing of the target (source count, id width, priority
// width) and the per-source gateway state encoding. The same encoding is
// used by the gateway, the priority-index tree and the claim/complete
// register logic, so it lives here rather than in any one module.
//
// Optional build macro: PLIC_EDGE_EN (edge-triggered sources, see
// plic_gateway_cell).
package plic_pkg;

  // Default configuration: 15 sources, ids 1..15, id 0 reserved for "none".
  localparam int NSRC_DEF = 15;
  localparam int IDW_DEF  = 4;
  localparam int PRW_DEF  = 3;

  // Gateway state encoding (2-bit, legacy-compatible constants).
  typedef logic [1:0] gw_state_t;
  localparam gw_state_t GW_IDLE    = 2'd0;
  localparam gw_state_t GW_PEND    = 2'd1;
  localparam gw_state_t GW_CLAIMED = 2'd2;

  // True when a one-cycle strobe carries the id of the given source.
  // Source k owns id k+1; id 0 and ids above the source count never match
  // because no source owns them.
  function automatic logic id_hit(input logic             strobe,
                                  input logic [IDW_DEF-1:0] id,
                                  input logic [IDW_DEF-1:0] src_id);
    return strobe && (id == src_id);
  endfunction

endpackage

// File: rtl/plic_gateway_if.sv
// plic_gateway_if: claim/complete notification bundle between the
// hart-facing claim/complete register logic (master) and the gateway
// array (slave).
//
// Signals:
//   claim_i        one-cycle claim strobe
//   claim_id_i     id being claimed
//   complete_i     one-cycle completion strobe
//   complete_id_i  id being completed
//
// Optional build macro: none.
interface plic_gateway_if #(
  parameter int IDW = plic_pkg::IDW_DEF
);

  logic           claim_i;
  logic [IDW-1:0] claim_id_i;
  logic           complete_i;
  logic [IDW-1:0] complete_id_i;

  modport master (
    output claim_i,
    output claim_id_i,
    output complete_i,
    output complete_id_i
  );

  modport slave (
    input claim_i,
    input claim_id_i,
    input complete_i,
    input complete_id_i
  );

endinterface

// File: rtl/plic_gateway_cell.sv
// plic_gateway_cell: one interrupt source's gateway.
//
// Tracks IDLE -> PEND -> CLAIMED -> IDLE for a single source. A request is
// only accepted in IDLE, so the gateway is closed while the source is
// pending or in service. Once pending, the source cannot withdraw it.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset (state -> IDLE)
//   src           raw interrupt line, synchronous to clk
//   edge_mode     1 = edge-triggered, 0 = level (only with PLIC_EDGE_EN)
//   claim_hit     claim strobe addressed to this source
//   complete_hit  complete strobe addressed to this source
//   pending       1 while the source is in PEND
//
// Optional build macro: PLIC_EDGE_EN. When defined, edge-mode sources
// detect rising edges against a registered copy of src and keep a one-deep
// latch of an edge that arrives while the gateway is closed; that latch
// re-requests the source once it is back in IDLE. When undefined, every
// source is level-triggered and no extra flops exist.
module plic_gateway_cell
  import plic_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  input  logic edge_mode,
  input  logic claim_hit,
  input  logic complete_hit,
  output logic pending
);

  gw_state_t state;
  gw_state_t state_nxt;
  logic      req;

`ifdef PLIC_EDGE_EN
  logic src_q;
  logic edge_q;
  logic edge_q_nxt;
  logic rise;

  assign rise = src & ~src_q;

  // A latched edge counts as a request regardless of the current mode so a
  // stored event is never lost if the mode is changed while it waits.
  assign req = (edge_mode ? rise : src) | edge_q;

  // The latch is consumed on the IDLE cycle that turns it into PEND. Edges
  // seen while closed set it; any further edges are simply absorbed.
  always_comb begin
    edge_q_nxt = edge_q;
    if (state == GW_IDLE) begin
      edge_q_nxt = 1'b0;
    end else if (edge_mode && rise) begin
      edge_q_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q  <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      src_q  <= src;
      edge_q <= edge_q_nxt;
    end
  end
`else
  logic unused_edge_mode;

  assign unused_edge_mode = edge_mode;
  assign req              = src;
`endif

  // Completion always lands in IDLE first; a source still requesting is
  // picked up from IDLE on the following edge (no CLAIMED -> PEND bypass).
  always_comb begin
    state_nxt = state;
    case (state)
      GW_IDLE:    if (req)          state_nxt = GW_PEND;
      GW_PEND:    if (claim_hit)    state_nxt = GW_CLAIMED;
      GW_CLAIMED: if (complete_hit) state_nxt = GW_IDLE;
      default:                      state_nxt = GW_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= GW_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign pending = (state == GW_PEND);

endmodule

// File: rtl/plic_gateway.sv
// plic_gateway: gateway array and pending bits for one PLIC target.
//
// One plic_gateway_cell per source turns raw lines into pending/claimed
// state. This level decodes claim/complete ids into per-source strobes and
// packs the id and priority vectors consumed by the priority-index tree.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   src_i      raw interrupt lines (NSRC), synchronous to clk
//   edge_i     per-source edge mode (used only with PLIC_EDGE_EN)
//   enable_i   per-source enable for this target
//   prio_i     per-source priority, slot k at [k*PRW +: PRW]
//   cc         claim/complete notifications (plic_gateway_if.slave)
//   pending_o  registered pending bits
//   id_o       slot k = k+1 when pending and enabled, else 0
//   prio_o     slot k = prio_i slot k when pending and enabled, else 0
//
// Optional build macro: PLIC_EDGE_EN (edge-triggered sources).
module plic_gateway
  import plic_pkg::*;
#(
  parameter int NSRC = NSRC_DEF,
  parameter int IDW  = IDW_DEF,
  parameter int PRW  = PRW_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NSRC-1:0]     src_i,
  input  logic [NSRC-1:0]     edge_i,
  input  logic [NSRC-1:0]     enable_i,
  input  logic [NSRC*PRW-1:0] prio_i,
  plic_gateway_if.slave       cc,
  output logic [NSRC-1:0]     pending_o,
  output logic [NSRC*IDW-1:0] id_o,
  output logic [NSRC*PRW-1:0] prio_o
);

  for (genvar k = 0; k < NSRC; k++) begin : g_src
    localparam logic [IDW-1:0] SRC_ID = IDW'(k + 1);

    logic claim_hit;
    logic complete_hit;
    logic active;

    // Ids 0 and > NSRC decode to no source at all, so they are dropped here.
    assign claim_hit    = cc.claim_i    && (cc.claim_id_i    == SRC_ID);
    assign complete_hit = cc.complete_i && (cc.complete_id_i == SRC_ID);

    plic_gateway_cell u_cell (
      .clk          (clk),
      .rst_n        (rst_n),
      .src          (src_i[k]),
      .edge_mode    (edge_i[k]),
      .claim_hit    (claim_hit),
      .complete_hit (complete_hit),
      .pending      (pending_o[k])
    );

    // Enable only masks what the tree sees; pending keeps accumulating.
    assign active                 = pending_o[k] & enable_i[k];
    assign id_o[k*IDW +: IDW]     = active ? SRC_ID : '0;
    assign prio_o[k*PRW +: PRW]   = active ? prio_i[k*PRW +: PRW] : '0;
  end

endmodule

// File: tb/tb_plic_gateway.sv
module tb_plic_gateway;

  localparam int NSRC = 15;
  localparam int IDW  = 4;
  localparam int PRW  = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NSRC-1:0]     src;
  logic [NSRC-1:0]     edg;
  logic [NSRC-1:0]     en;
  logic [NSRC*PRW-1:0] prio;
  logic [NSRC-1:0]     pending_o;
  logic [NSRC*IDW-1:0] id_o;
  logic [NSRC*PRW-1:0] prio_o;

  plic_gateway_if #(.IDW(IDW)) cc ();

  plic_gateway #(.NSRC(NSRC), .IDW(IDW), .PRW(PRW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_i     (src),
    .edge_i    (edg),
    .enable_i  (en),
    .prio_i    (prio),
    .cc        (cc),
    .pending_o (pending_o),
    .id_o      (id_o),
    .prio_o    (prio_o)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  // Reference: each source is "waiting" (pending), "in service", or free.
  bit m_pend [NSRC];
  bit m_busy [NSRC];
  bit m_srcq [NSRC];
  bit m_edq  [NSRC];

  task automatic model_reset();
    for (int k = 0; k < NSRC; k++) begin
      m_pend[k] = 0; m_busy[k] = 0; m_srcq[k] = 0; m_edq[k] = 0;
    end
  endtask

  task automatic model_clock();
    for (int k = 0; k < NSRC; k++) begin
      bit cl, co, free, rise, em, np, nb, ne;
      cl   = cc.claim_i    && (int'(cc.claim_id_i)    == k + 1);
      co   = cc.complete_i && (int'(cc.complete_id_i) == k + 1);
      free = !m_pend[k] && !m_busy[k];
      rise = src[k] && !m_srcq[k];
`ifdef PLIC_EDGE_EN
      em = edg[k];
`else
      em = 0;
`endif
      np = m_pend[k]; nb = m_busy[k]; ne = m_edq[k];
      if (m_pend[k] && cl) begin
        np = 0; nb = 1;
      end else if (m_busy[k] && co) begin
        nb = 0;
      end else if (free) begin
        if (m_edq[k] || (em ? rise : src[k])) np = 1;
        ne = 0;
      end
      if (!free && em && rise) ne = 1;
      m_pend[k] = np; m_busy[k] = nb; m_edq[k] = ne;
`ifdef PLIC_EDGE_EN
      m_srcq[k] = src[k];
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(string tag);
    logic [NSRC-1:0]     ep;
    logic [NSRC*IDW-1:0] ei;
    logic [NSRC*PRW-1:0] er;
    for (int k = 0; k < NSRC; k++) begin
      bit act;
      ep[k] = m_pend[k];
      act   = m_pend[k] && en[k];
      ei[k*IDW +: IDW] = act ? IDW'(k + 1) : '0;
      er[k*PRW +: PRW] = act ? prio[k*PRW +: PRW] : '0;
    end
    chk({tag, ".pend"}, 64'(pending_o), 64'(ep));
    chk({tag, ".id"},   64'(id_o),      64'(ei));
    chk({tag, ".prio"}, 64'(prio_o),    64'(er));
  endtask

  task automatic strobe_claim(int id);
    cc.claim_i = 1'b1; cc.claim_id_i = IDW'(id);
    tick();
    cc.claim_i = 1'b0; cc.claim_id_i = '0;
  endtask

  task automatic strobe_complete(int id);
    cc.complete_i = 1'b1; cc.complete_id_i = IDW'(id);
    tick();
    cc.complete_i = 1'b0; cc.complete_id_i = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    int pick [$];
    rst_n = 1'b0; src = '0; edg = '0; en = '0; prio = '0;
    cc.claim_i = 1'b0; cc.claim_id_i = '0;
    cc.complete_i = 1'b0; cc.complete_id_i = '0;
    do_reset();
    check_outputs("reset");
    chk("reset.pend0", 64'(pending_o), 64'd0);

    // Level request on source 2
    src[2] = 1'b1; prio[2*PRW +: PRW] = 3'd5; en[2] = 1'b1;
    tick();
    check_outputs("lvl");
    chk("lvl.pend2", 64'(pending_o[2]), 64'd1);
    chk("lvl.id2",   64'(id_o[2*IDW +: IDW]), 64'd3);
    chk("lvl.prio2", 64'(prio_o[2*PRW +: PRW]), 64'd5);

    // Claim, then complete with the line still high
    strobe_claim(3);
    check_outputs("claim");
    chk("claim.pend2", 64'(pending_o[2]), 64'd0);
    chk("claim.id2",   64'(id_o[2*IDW +: IDW]), 64'd0);
    strobe_complete(3);
    check_outputs("cmpl1");
    chk("cmpl1.pend2", 64'(pending_o[2]), 64'd0);
    tick();
    check_outputs("cmpl2");
    chk("rearm.pend2", 64'(pending_o[2]), 64'd1);

    // Masking on source 0
    src[0] = 1'b1; en[0] = 1'b0; prio[0 +: PRW] = 3'd6;
    tick();
    check_outputs("mask");
    chk("mask.pend0", 64'(pending_o[0]), 64'd1);
    chk("mask.id0",   64'(id_o[0 +: IDW]), 64'd0);
    chk("mask.prio0", 64'(prio_o[0 +: PRW]), 64'd0);
    en[0] = 1'b1;
    #1;
    check_outputs("unmask");
    chk("unmask.id0", 64'(id_o[0 +: IDW]), 64'd1);

    // Ignored claim/complete operations
    src[3] = 1'b1;
    tick();
    strobe_claim(0);
    check_outputs("ign.id0");
    strobe_claim(15);
    check_outputs("ign.id15");
    strobe_complete(4);
    check_outputs("ign.cmpl4");
    chk("ign.pend3", 64'(pending_o[3]), 64'd1);
    src[14] = 1'b1;
    tick();
    check_outputs("src14");
    chk("src14.pend", 64'(pending_o[14]), 64'd1);
    strobe_claim(15);
    src[14] = 1'b0;
    check_outputs("src14.claim");
    chk("src14.claimed", 64'(pending_o[14]), 64'd0);

    // Asynchronous reset while source 5 is in service
    src[5] = 1'b1;
    tick();
    strobe_claim(6);
    check_outputs("svc5");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("arst");
    chk("arst.pend", 64'(pending_o), 64'd0);
    #2 rst_n = 1'b1;
    tick();
    check_outputs("arst.rel");
    chk("arst.pend5", 64'(pending_o[5]), 64'd1);

`ifdef PLIC_EDGE_EN
    // Edge mode on source 1
    src = '0; en = '1;
    do_reset();
    edg[1] = 1'b1;
    src[1] = 1'b1; tick(); src[1] = 1'b0;
    check_outputs("edge.req");
    chk("edge.pend1", 64'(pending_o[1]), 64'd1);
    strobe_claim(2);
    src[1] = 1'b1; tick(); src[1] = 1'b0; tick();
    src[1] = 1'b1; tick(); src[1] = 1'b0; tick();
    check_outputs("edge.busy");
    strobe_complete(2);
    check_outputs("edge.cmpl");
    chk("edge.idle1", 64'(pending_o[1]), 64'd0);
    tick();
    check_outputs("edge.rereq");
    chk("edge.rereq1", 64'(pending_o[1]), 64'd1);
    strobe_claim(2);
    strobe_complete(2);
    tick(); tick();
    check_outputs("edge.done");
    chk("edge.done1", 64'(pending_o[1]), 64'd0);
`endif

    // Randomized traffic against the reference
    edg = NSRC'($urandom);
    src = '0;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      src  = NSRC'($urandom & $urandom);
      en   = NSRC'($urandom);
      prio = {$urandom, $urandom};
      pick.delete();
      for (int k = 0; k < NSRC; k++) if (m_pend[k]) pick.push_back(k + 1);
      cc.claim_i = ($urandom_range(0, 1) == 1);
      if (pick.size() > 0 && $urandom_range(0, 3) != 0)
        cc.claim_id_i = IDW'(pick[$urandom_range(0, pick.size() - 1)]);
      else
        cc.claim_id_i = IDW'($urandom_range(0, 15));
      pick.delete();
      for (int k = 0; k < NSRC; k++) if (m_busy[k]) pick.push_back(k + 1);
      cc.complete_i = ($urandom_range(0, 1) == 1);
      if (pick.size() > 0 && $urandom_range(0, 3) != 0)
        cc.complete_id_i = IDW'(pick[$urandom_range(0, pick.size() - 1)]);
      else
        cc.complete_id_i = IDW'($urandom_range(0, 15));
      tick();
      cc.claim_i = 1'b0; cc.complete_i = 1'b0;
      check_outputs("rand");
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/plic_gateway.md
Name: plic_gateway

Overview:
- Upstream stage of the PLIC target: one gateway per interrupt source plus the pending array.
- Converts raw source lines into per-source pending/claimed state.
- Drives the packed id and priority vectors that the target's priority-index tree consumes.
- Accepts claim and complete notifications from the hart-facing claim/complete register logic.

Parameters:
- NSRC, 15, number of interrupt sources; source k has id k+1, id 0 means "none".
- IDW, 4, id width; must satisfy 2^IDW > NSRC.
- PRW, 3, priority width per source.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- src_i  input  NSRC  raw interrupt lines, already synchronous to clk
- edge_i  input  NSRC  per-source mode: 1 = edge-triggered, 0 = level (used only with PLIC_EDGE_EN)
- enable_i  input  NSRC  per-source enable for this target
- prio_i  input  NSRC*PRW  per-source priority; slot k at [k*PRW +: PRW]
- claim_i  input  1  one-cycle claim strobe
- claim_id_i  input  IDW  id being claimed
- complete_i  input  1  one-cycle completion strobe
- complete_id_i  input  IDW  id being completed
- pending_o  output  NSRC  registered pending bits
- id_o  output  NSRC*IDW  slot k = k+1 when pending_o[k] & enable_i[k], else 0
- prio_o  output  NSRC*PRW  slot k = prio_i slot k when pending_o[k] & enable_i[k], else 0

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Asynchronous active-low reset puts every source in IDLE, so pending_o = 0 and id_o/prio_o = 0.
- Per-source state machine (2-bit):
  - IDLE -> PEND when the request condition is true at a clk edge.
  - PEND -> CLAIMED on claim_i with claim_id_i == k+1.
  - CLAIMED -> IDLE on complete_i with complete_id_i == k+1.
- Request condition:
  - Level mode: src_i[k] == 1.
- Pending:
  - pending_o[k] = (state == PEND), registered.
  - Latency: src_i rises in cycle N, pending_o[k] = 1 in cycle N+1.
- Pending persistence: a level source that deasserts while in PEND stays PEND; pending is never withdrawn by the source.
- Gateway closed: while in PEND or CLAIMED, further requests are not forwarded.
- Re-arm: in level mode, a source still high at completion goes CLAIMED -> IDLE in cycle N, then PEND in cycle N+1. There is no bypass from CLAIMED directly to PEND.
- Claim and complete filtering:
  - claim_id_i == 0 or > NSRC: ignored.
  - Claim of a source not in PEND: ignored.
  - Complete of a source not in CLAIMED: ignored; there are no error outputs.
- Simultaneous events:
  - claim_i and complete_i may arrive in the same cycle for different ids; both take effect.
  - For the same id the two cannot both match, since a source is in only one state.
- Disabled sources:
  - enable_i does not block pending accumulation; it only masks id_o/prio_o, combinationally.
  - A disabled source can still be claimed or completed.
- Output shaping:
  - id_o and prio_o are combinational from registered state, enable_i and prio_i, so the target registers them one cycle later.
- Reset mid-operation: all in-service (CLAIMED) sources return to IDLE; there is no replay.

Optional Feature:
- Macro: PLIC_EDGE_EN.
- Defined:
  - Sources with edge_i[k] = 1 detect rising edges using a per-source registered copy of src_i.
  - A rising edge in IDLE -> PEND.
  - A rising edge seen in PEND or CLAIMED sets a one-deep latch edge_q[k]. On completion, edge_q[k] = 1 moves the source to IDLE and re-requests next cycle, then clears the latch.
  - Further edges beyond one are dropped.
  - src_q and edge_q reset to 0.
- Undefined:
  - edge_i is ignored and all sources are level-triggered.
  - No src_q/edge_q flops are generated.

Decomposition:
- Package plic_pkg:
  - NSRC, IDW, PRW defaults.
  - Gateway state encoding: IDLE = 2'd0, PEND = 2'd1, CLAIMED = 2'd2.
  - Shared with target and the claim/complete logic.
- Sub-module plic_gateway_cell: one source's state machine plus edge logic, instantiated NSRC times under a generate loop.
- The top level does id/priority packing and claim/complete id decode.

Test Plan:
- Level request: src_i[2] = 1, prio_i slot2 = 5, enable_i[2] = 1 -> next cycle pending_o[2] = 1, id_o slot2 = 3, prio_o slot2 = 5.
- Claim/complete:
  - claim_i with claim_id_i = 3 -> pending_o[2] = 0, id_o slot2 = 0.
  - Hold src_i[2] = 1, then complete_id_i = 3 -> pending_o[2] = 1 two cycles after the complete strobe.
- Masking: src_i[0] = 1 with enable_i[0] = 0 -> pending_o[0] = 1 but id_o slot0 = 0 and prio_o slot0 = 0. Setting enable_i[0] = 1 -> id_o slot0 = 1 in the same cycle.
- Ignored ops:
  - claim_id_i = 0, claim_id_i = 15 on idle source 14, and complete_id_i = 4 while source 3 is PEND -> no state change.
  - Source 14 is then PENDed and claimed with id 15 -> works.
- Reset mid-service: source 5 in CLAIMED, pulse rst_n low asynchronously mid-cycle -> pending_o = 0 immediately. With src_i[5] still high, PEND one cycle after reset release.
- Edge mode (PLIC_EDGE_EN, edge_i[1] = 1):
  - Pulse src_i[1] -> PEND.
  - Claim id 2, then two pulses during CLAIMED, then complete id 2 -> exactly one re-request, pending_o[1] = 1 once.
  - After a second claim/complete -> remains IDLE.
